reqack_tph_rr_arbiter: RTL and testbench
========================================

Name: reqack_tph_rr_arbiter

Overview:
Round-robin arbiter that shares one downstream two-phase req/ack channel among NREQ upstream two-phase channels.
- Sits in front of a reqack_tph_pipe_stage chain (or any two-phase consumer).
- Forwards one transfer at a time, with a requester-ID tag.
- Returns the upstream ack only after the downstream ack, so completion is end-to-end.

Parameters:
NREQ, 2, number of upstream requesters (>=2).
DWIDTH, 1, data path bit width per requester.
INCLUDE_CDC_PRV, 1'b0, 2-flop synchronizer on every req[i] input.
INCLUDE_CDC_NXT, 1'b0, 2-flop synchronizer on ack_nxt input.

Ports:
clk  input  1  rising edge active clock.
rst_n  input  1  asynchronous reset, active low.
req  input  NREQ  upstream two-phase requests, one bit per requester.
ack  output  NREQ  upstream two-phase acknowledges.
i_dat  input  NREQ x DWIDTH  upstream data; stable while that requester's req != ack.
req_nxt  output  1  downstream two-phase request.
ack_nxt  input  1  downstream two-phase acknowledge.
o_dat  output  DWIDTH  registered data of the granted requester.
o_id  output  IDW  registered index of the granted requester; IDW = max(1,$clog2(NREQ)).

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active low.
- Internal signals: req_i and ack_nxt_i are the synchronized versions when CDC is enabled, else the raw inputs. Each synchronizer adds 2 cycles of latency and resets to 0.
- Pending requester i: req_i[i] != ack[i]. Downstream idle: req_nxt == ack_nxt_i.
- State IDLE (downstream idle), on a clock edge with at least one pending requester:
  - grant g = first pending index searching ptr+1, ptr+2, ... modulo NREQ;
  - toggle req_nxt, load o_dat <= i_dat[g], o_id <= g, gidx <= g;
  - go to BUSY.
- State IDLE with no requester pending: hold all outputs.
- State BUSY:
  - wait for ack_nxt_i == req_nxt;
  - on that edge toggle ack[gidx], set ptr <= gidx, go to IDLE.
- Changes on other req bits while BUSY only become pending; they do not disturb the current transfer.
- Latency:
  - pending req_i to req_nxt toggle: 1 cycle;
  - ack_nxt_i match to ack[g] toggle: 1 cycle;
  - the next grant is issued at the earliest on the edge after the completion edge, so there is exactly one IDLE cycle between transfers.
- Fairness: a requester that stays pending is granted within NREQ transfers. There is no starvation.
- Simultaneous pending requests: only one grant per cycle, chosen by the round-robin order above.
- Requester whose ack was just toggled: it is not pending again until it toggles req.
- Protocol violation (a granted requester toggles req back before its ack): ignored. The transfer completes normally, and that requester is then seen as pending with the opposite phase.
- Reset values (also on reset mid-operation):
  - req_nxt=0, ack='0, o_id=0, state=IDLE, gidx=0;
  - ptr=NREQ-1, so index 0 has first priority after reset.
- o_dat has no reset; it is undefined until the first grant.
- Reset mid-transfer abandons the transfer. The environment must reset the downstream side together with the arbiter.
- The data register loads only on a grant edge and is otherwise held.

Decomposition:
- Package reqack_tph_pkg:
  - state typedef (enum IDLE, BUSY);
  - function rr_pick(pending, ptr) returning the index plus a valid flag;
  - function clog2-min-1 for IDW.
- Sub-module reqack_tph_cdc_sync, parameterized width, 2-flop, async reset to 0. Instantiated once for req (width NREQ) and once for ack_nxt (width 1) under the CDC generates.

Test Plan:
- Single request, no CDC, NREQ=2, ack_nxt looped back after 3 cycles: toggle req[1] with i_dat[1]=1 -> req_nxt toggles at +1 cycle, o_dat=1, o_id=1; ack[1] toggles 1 cycle after ack_nxt matches; req_nxt/ack untouched otherwise.
- Both requesters pending continuously after reset, NREQ=2: grant order is 0,1,0,1; each ack toggles once per grant; one idle cycle between transfers.
- NREQ=4, requesters 1 and 3 pending, ptr=1: grant goes to 3 first, then 1; requester 0 toggling req mid-transfer is granted next after 1 (order 3,1,0).
- Back-pressure: ack_nxt withheld 20 cycles while all requesters are pending -> req_nxt stable, o_dat/o_id stable, no ack toggles until ack_nxt matches.
- Reset asserted while BUSY: outputs go to req_nxt=0, ack='0, o_id=0 immediately (asynchronously); after release, pending requester 0 wins first.
- INCLUDE_CDC_PRV=1, INCLUDE_CDC_NXT=1: req[0] toggle -> req_nxt toggles 3 cycles later; ack_nxt toggle -> ack[0] toggles 3 cycles later.

Source files
------------

// File: rtl/reqack_tph_pkg.sv
// Shared types and helpers for the two-phase req/ack round-robin arbiter.
package reqack_tph_pkg;

  // Arbiter control states: IDLE while the downstream channel is free,
  // BUSY while a forwarded transfer waits for its downstream acknowledge.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Widest requester vector rr_pick can search; callers zero-extend into it.
  localparam int unsigned RR_MAX_NREQ = 64;

  // Index width for n requesters, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = $clog2(n);
    if (r < 1) r = 1;
    return r;
  endfunction

  // Round-robin search: first pending index among ptr+1, ptr+2, ... mod nreq.
  // Returns the valid flag; the chosen index comes back through idx.
  // ptr must be below nreq, so ptr+k never needs more than one wrap.
  function automatic logic rr_pick(input  logic [RR_MAX_NREQ-1:0] pending,
                                   input  int unsigned            ptr,
                                   input  int unsigned            nreq,
                                   output int unsigned            idx);
    logic        found;
    int unsigned cand;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 1; k <= RR_MAX_NREQ; k++) begin
      cand = ptr + k;
      if (cand >= nreq) cand = cand - nreq;
      if (!found && (k <= nreq) &&
          (|(pending & (RR_MAX_NREQ'(1) << cand)))) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return found;
  endfunction

endpackage

// File: rtl/reqack_tph_cdc_sync.sv
// Two-flop synchronizer for a vector of level (two-phase) signals.
// Each bit is synchronized independently; safe because two-phase
// handshake lines change at most one bit per transfer per channel.
module reqack_tph_cdc_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two-stage shift, cleared to 0 on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/reqack_tph_rr_arbiter.sv
// Round-robin arbiter: NREQ upstream two-phase channels share one
// downstream two-phase channel. One transfer in flight at a time; the
// upstream ack is returned only after the downstream ack (end-to-end).
// NREQ must lie in 2..RR_MAX_NREQ.
module reqack_tph_rr_arbiter
  import reqack_tph_pkg::*;
#(
  parameter  int unsigned NREQ            = 2,
  parameter  int unsigned DWIDTH          = 1,
  parameter  bit          INCLUDE_CDC_PRV = 1'b0,
  parameter  bit          INCLUDE_CDC_NXT = 1'b0,
  localparam int unsigned IDW             = clog2_min1(NREQ)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NREQ-1:0]             req,
  output logic [NREQ-1:0]             ack,
  input  logic [NREQ-1:0][DWIDTH-1:0] i_dat,
  output logic                        req_nxt,
  input  logic                        ack_nxt,
  output logic [DWIDTH-1:0]           o_dat,
  output logic [IDW-1:0]              o_id
);

  logic [NREQ-1:0] req_i;
  logic            ack_nxt_i;

  // Optional synchronizers on the asynchronous handshake inputs.
  if (INCLUDE_CDC_PRV) begin : g_cdc_prv
    reqack_tph_cdc_sync #(.WIDTH(NREQ)) u_sync_req (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (req),
      .q     (req_i)
    );
  end else begin : g_no_cdc_prv
    assign req_i = req;
  end

  if (INCLUDE_CDC_NXT) begin : g_cdc_nxt
    reqack_tph_cdc_sync #(.WIDTH(1)) u_sync_ack_nxt (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (ack_nxt),
      .q     (ack_nxt_i)
    );
  end else begin : g_no_cdc_nxt
    assign ack_nxt_i = ack_nxt;
  end

  arb_state_t                 state_q, state_d;
  logic [IDW-1:0]             ptr_q, ptr_d;
  logic [IDW-1:0]             gidx_q, gidx_d;
  logic [NREQ-1:0]            ack_d;
  logic                       req_nxt_d;
  logic [IDW-1:0]             o_id_d;
  logic                       grant;

  logic [NREQ-1:0]            pending;
  logic                       ds_done;
  logic [RR_MAX_NREQ-1:0]     pend_ext;
  logic                       pick_valid;
  int unsigned                pick_idx;
  logic [NREQ-1:0]            gidx_onehot;

  // Pending / downstream-done detection and the round-robin pick.
  always_comb begin
    pending  = req_i ^ ack;
    ds_done  = (req_nxt == ack_nxt_i);
    pend_ext = '0;
    pend_ext[NREQ-1:0] = pending;
    pick_idx   = 0;
    pick_valid = rr_pick(pend_ext, 32'(ptr_q), NREQ, pick_idx);
    gidx_onehot = '0;
    gidx_onehot[gidx_q] = 1'b1;
  end

  // Next-state and output logic; everything holds unless a grant or a
  // completion happens on this edge.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gidx_d    = gidx_q;
    ack_d     = ack;
    req_nxt_d = req_nxt;
    o_id_d    = o_id;
    grant     = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant     = 1'b1;
          req_nxt_d = ~req_nxt;
          gidx_d    = IDW'(pick_idx);
          o_id_d    = IDW'(pick_idx);
          state_d   = BUSY;
        end
      end
      BUSY: begin
        // Completion returns to IDLE, so the next grant is one edge later.
        if (ds_done) begin
          ack_d   = ack ^ gidx_onehot;
          ptr_d   = gidx_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and handshake registers; ptr starts at NREQ-1 so index 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= IDW'(NREQ - 1);
      gidx_q  <= '0;
      ack     <= '0;
      req_nxt <= 1'b0;
      o_id    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      ack     <= ack_d;
      req_nxt <= req_nxt_d;
      o_id    <= o_id_d;
    end
  end

  // Data register: loaded only on a grant edge, no reset.
  always_ff @(posedge clk) begin
    if (grant) o_dat <= i_dat[gidx_d];
  end

endmodule

// File: tb/tb_reqack_tph_rr_arbiter.sv
// Scoreboard bench for reqack_tph_rr_arbiter: a transaction-level model
// predicts grants into a queue; a monitor pops and compares on each
// downstream request toggle and checks handshake levels every cycle.
module tb_reqack_tph_rr_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned IW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_n;
  logic [N-1:0]           req, ack;
  logic [N-1:0][DW-1:0]   i_dat;
  logic                   req_nxt, ack_nxt;
  logic [DW-1:0]          o_dat;
  logic [IW-1:0]          o_id;

  reqack_tph_rr_arbiter #(
    .NREQ(N), .DWIDTH(DW), .INCLUDE_CDC_PRV(1'b0), .INCLUDE_CDC_NXT(1'b0)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .ack(ack), .i_dat(i_dat),
    .req_nxt(req_nxt), .ack_nxt(ack_nxt), .o_dat(o_dat), .o_id(o_id)
  );

  logic [1:0]      c_req, c_ack;
  logic [1:0][0:0] c_i_dat;
  logic            c_req_nxt, c_ack_nxt;
  logic [0:0]      c_o_dat;
  logic [0:0]      c_o_id;

  reqack_tph_rr_arbiter #(
    .NREQ(2), .DWIDTH(1), .INCLUDE_CDC_PRV(1'b1), .INCLUDE_CDC_NXT(1'b1)
  ) u_cdc (
    .clk(clk), .rst_n(rst_n), .req(c_req), .ack(c_ack), .i_dat(c_i_dat),
    .req_nxt(c_req_nxt), .ack_nxt(c_ack_nxt), .o_dat(c_o_dat), .o_id(c_o_id)
  );

  typedef struct packed {logic [IW-1:0] id; logic [DW-1:0] dat;} gnt_t;
  typedef struct {string nm; logic [31:0] a; logic [31:0] e;} dchk_t;

  gnt_t        gq[$];
  dchk_t       dq[$];
  int unsigned gnt_log[$];
  int          chk = 0;
  int          err = 0;

  // Reference model state (transaction level).
  bit          m_busy;
  int unsigned m_ptr, m_gidx;
  logic [N-1:0] m_ack;
  logic        m_req_nxt;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_busy = 0; m_ptr = N - 1; m_gidx = 0; m_ack = '0; m_req_nxt = 1'b0;
        gq.delete();
      end else if (!m_busy) begin
        for (int unsigned k = 1; k <= N; k++) begin
          int unsigned cand;
          cand = (m_ptr + k) % N;
          if (req[cand] != m_ack[cand]) begin
            gq.push_back('{id: IW'(cand), dat: i_dat[cand]});
            m_gidx = cand; m_busy = 1; m_req_nxt = ~m_req_nxt;
            break;
          end
        end
      end else if (ack_nxt == m_req_nxt) begin
        m_ack[m_gidx] = ~m_ack[m_gidx];
        m_ptr  = m_gidx;
        m_busy = 0;
      end
    end
  end

  task automatic check(string nm, logic [31:0] a, logic [31:0] e);
    chk++;
    if (a !== e) begin
      err++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  function automatic void expect_eq(string nm, logic [31:0] a, logic [31:0] e);
    dq.push_back('{nm: nm, a: a, e: e});
  endfunction

  // Monitor: owns the counters; compares DUT against the model every
  // negedge and drains directed expectations queued by the stimulus.
  logic        prev_rn;
  logic [IW-1:0] last_id;
  logic [DW-1:0] last_dat;
  bit          have_last = 0;
  gnt_t        mon_g;
  dchk_t       mon_d;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_rn = 1'b0;
        last_id = '0;
      end else begin
        check("req_nxt", 32'(req_nxt), 32'(m_req_nxt));
        check("ack", 32'(ack), 32'(m_ack));
        if (req_nxt !== prev_rn) begin
          if (gq.size() == 0) check("grant_q_empty", 32'(gq.size()), 32'd1);
          else begin
            mon_g = gq.pop_front();
            check("o_id", 32'(o_id), 32'(mon_g.id));
            check("o_dat", 32'(o_dat), 32'(mon_g.dat));
            last_id = mon_g.id; last_dat = mon_g.dat; have_last = 1;
            gnt_log.push_back(32'(mon_g.id));
          end
        end else if (have_last) begin
          check("o_id_hold", 32'(o_id), 32'(last_id));
          check("o_dat_hold", 32'(o_dat), 32'(last_dat));
        end
        prev_rn = req_nxt;
      end
      while (dq.size() != 0) begin
        mon_d = dq.pop_front();
        check(mon_d.nm, mon_d.a, mon_d.e);
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Stimulus environment knobs.
  logic [N-1:0] auto_en = '0;
  int unsigned  p_pct   = 0;
  bit           viol_en = 0;
  bit           resp_en = 0;
  bit           rand_dly = 0;
  int unsigned  ack_dly = 2;
  int unsigned  dcnt    = 0;

  // One cycle of environment: random requesters and the downstream responder.
  task automatic step();
    @(negedge clk); #1;
    for (int i = 0; i < N; i++) begin
      if (auto_en[i]) begin
        if (req[i] == ack[i]) begin
          if ($urandom_range(99) < p_pct) begin
            i_dat[i] = DW'($urandom);
            req[i]   = ~req[i];
          end
        end else if (viol_en && ($urandom_range(199) == 0)) begin
          req[i] = ~req[i];
        end
      end
    end
    if (resp_en && (req_nxt != ack_nxt)) begin
      if (dcnt >= ack_dly) begin
        ack_nxt = req_nxt;
        dcnt = 0;
        if (rand_dly) ack_dly = $urandom_range(0, 4);
      end else dcnt++;
    end
  endtask

  task automatic wait_idle(string nm);
    int unsigned n = 0;
    while (!((req == ack) && (req_nxt == ack_nxt)) && (n < 300)) begin
      step(); n++;
    end
    expect_eq(nm, 32'(n < 300), 32'd1);
  endtask

  task automatic wait_grants(int unsigned target, string nm);
    int unsigned n = 0;
    while ((gnt_log.size() < target) && (n < 500)) begin
      step(); n++;
    end
    expect_eq(nm, 32'(gnt_log.size() >= target), 32'd1);
  endtask

  int unsigned  base, n;
  logic         snap_rn;
  logic [IW-1:0] snap_id;
  logic [DW-1:0] snap_dat;
  logic [N-1:0] snap_ack;

  initial begin
    rst_n = 1'b0; req = '0; i_dat = '0; ack_nxt = 1'b0;
    c_req = '0; c_i_dat = '0; c_ack_nxt = 1'b0;
    repeat (3) step();
    expect_eq("rst_req_nxt", 32'(req_nxt), 32'd0);
    expect_eq("rst_ack", 32'(ack), 32'd0);
    expect_eq("rst_o_id", 32'(o_id), 32'd0);
    rst_n = 1'b1;
    step();

    // Single request on requester 1, manual downstream ack.
    i_dat[1] = 8'h01; req[1] = ~req[1];
    step();
    expect_eq("single_req_nxt", 32'(req_nxt), 32'd1);
    expect_eq("single_o_id", 32'(o_id), 32'd1);
    expect_eq("single_o_dat", 32'(o_dat), 32'h01);
    repeat (3) step();
    expect_eq("single_ack_held", 32'(ack), 32'd0);
    ack_nxt = req_nxt;
    step();
    expect_eq("single_ack_lat", 32'(ack), 32'b0010);
    expect_eq("single_req_nxt_held", 32'(req_nxt), 32'd1);

    // Requesters 0 and 1 continuously pending: alternate 0,1,0,1.
    resp_en = 1; ack_dly = 2;
    base = gnt_log.size();
    auto_en = 4'b0011; p_pct = 100;
    wait_grants(base + 4, "alt_grants");
    auto_en = '0;
    expect_eq("alt_0", gnt_log[base],     32'd0);
    expect_eq("alt_1", gnt_log[base + 1], 32'd1);
    expect_eq("alt_2", gnt_log[base + 2], 32'd0);
    expect_eq("alt_3", gnt_log[base + 3], 32'd1);
    wait_idle("alt_idle");

    // Park ptr at 1, then 1 and 3 pending; 0 joins during 1's transfer.
    i_dat[1] = 8'h21; req[1] = ~req[1];
    wait_idle("park_idle");
    ack_dly = 6;
    base = gnt_log.size();
    i_dat[1] = 8'h11; req[1] = ~req[1];
    i_dat[3] = 8'h33; req[3] = ~req[3];
    wait_grants(base + 2, "ord_two");
    i_dat[0] = 8'h55; req[0] = ~req[0];
    wait_grants(base + 3, "ord_three");
    expect_eq("ord_0", gnt_log[base],     32'd3);
    expect_eq("ord_1", gnt_log[base + 1], 32'd1);
    expect_eq("ord_2", gnt_log[base + 2], 32'd0);
    wait_idle("ord_idle");

    // Back-pressure: downstream withholds ack for 20 cycles.
    ack_dly = 20; auto_en = '1; p_pct = 100;
    base = gnt_log.size();
    wait_grants(base + 1, "bp_first");
    snap_rn = req_nxt; snap_id = o_id; snap_dat = o_dat; snap_ack = ack;
    repeat (15) step();
    expect_eq("bp_req_nxt", 32'(req_nxt), 32'(snap_rn));
    expect_eq("bp_o_id", 32'(o_id), 32'(snap_id));
    expect_eq("bp_o_dat", 32'(o_dat), 32'(snap_dat));
    expect_eq("bp_ack", 32'(ack), 32'(snap_ack));
    wait_grants(base + 3, "bp_more");
    auto_en = '0; ack_dly = 1;
    wait_idle("bp_idle");

    // Randomized traffic with random downstream delay and protocol violations.
    auto_en = '1; p_pct = 30; rand_dly = 1; viol_en = 1;
    repeat (1500) step();
    auto_en = '0; viol_en = 0; rand_dly = 0; ack_dly = 1;
    wait_idle("rand_idle");

    // Reset while BUSY.
    resp_en = 0;
    i_dat[2] = 8'hA5; req[2] = ~req[2];
    step(); step();
    i_dat[0] = 8'h3C;
    if (req[0] == ack[0]) req[0] = ~req[0];
    step();
    #2 rst_n = 1'b0; ack_nxt = 1'b0;
    #1;
    expect_eq("rstmid_req_nxt", 32'(req_nxt), 32'd0);
    expect_eq("rstmid_ack", 32'(ack), 32'd0);
    expect_eq("rstmid_o_id", 32'(o_id), 32'd0);
    req = 4'b0101;
    step(); step();
    rst_n = 1'b1; resp_en = 1; ack_dly = 1;
    base = gnt_log.size();
    wait_grants(base + 2, "rstmid_grants");
    expect_eq("rstmid_first", gnt_log[base],     32'd0);
    expect_eq("rstmid_second", gnt_log[base + 1], 32'd2);
    wait_idle("rstmid_idle");

    // CDC instance: each direction costs two sync flops plus one edge.
    c_i_dat[0] = 1'b1; c_req[0] = 1'b1;
    n = 0;
    while ((c_req_nxt == 1'b0) && (n < 10)) begin step(); n++; end
    expect_eq("cdc_req_lat", 32'(n), 32'd3);
    expect_eq("cdc_o_id", 32'(c_o_id), 32'd0);
    expect_eq("cdc_o_dat", 32'(c_o_dat), 32'd1);
    c_ack_nxt = c_req_nxt;
    n = 0;
    while ((c_ack[0] == 1'b0) && (n < 10)) begin step(); n++; end
    expect_eq("cdc_ack_lat", 32'(n), 32'd3);
    expect_eq("cdc_ack_other", 32'(c_ack[1]), 32'd0);

    step(); step();
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule
